// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the set-associative data cache.
// Latency: n/a (types only).
// Backpressure: n/a.
package dcache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        FILL,
        FILL_WAIT,
        WRITE,
        WRITE_WAIT,
        RESP
    } dcache_state_e;

    // Index width that never collapses to zero bits for single-entry structures.
    function automatic int unsigned dc_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned dc_words(input int unsigned line_bytes, input int unsigned data_w);
        return (line_bytes * 8) / data_w;
    endfunction

endpackage

// File: rtl/dcache_way.sv
// One cache way: valid bits, tag and line storage with async read and line/word write.
// Latency: read combinational, writes land on the next clock edge.
// Backpressure: none; writes are always accepted.
module dcache_way #(
    parameter int unsigned NUM_SETS = 256,
    parameter int unsigned IDX_W    = 8,
    parameter int unsigned TAG_W    = 50,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned LINE_W   = 512,
    parameter int unsigned WOFF_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_inv_all,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [TAG_W-1:0]  i_tag,
    input  logic [WOFF_W-1:0] i_woff,
    input  logic              i_line_we,
    input  logic [LINE_W-1:0] i_line_data,
    input  logic              i_word_we,
    input  logic [DATA_W-1:0] i_word_data,
    output logic [TAG_W-1:0]  o_tag,
    output logic              o_valid,
    output logic [LINE_W-1:0] o_line
);

    logic [NUM_SETS-1:0] r_valid;
    logic [TAG_W-1:0]    r_tag  [NUM_SETS];
    logic [LINE_W-1:0]   r_data [NUM_SETS];

    // A fill in the same cycle as invalidate-all still sets its valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            if (i_inv_all) begin
                r_valid <= '0;
            end
            if (i_line_we) begin
                r_valid[i_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_line_we) begin
            r_tag[i_idx]  <= i_tag;
            r_data[i_idx] <= i_line_data;
        end else if (i_word_we) begin
            r_data[i_idx][i_woff*DATA_W +: DATA_W] <= i_word_data;
        end
    end

    assign o_tag   = r_tag[i_idx];
    assign o_valid = r_valid[i_idx];
    assign o_line  = r_data[i_idx];

endmodule

// File: rtl/dcache_assoc.sv
// Set-associative write-through, no-write-allocate L1 D-cache; DCACHE_STATS_EN adds hit/miss counters.
// Latency: load hit responds 2 cycles after acceptance, miss adds memory latency + 1.
// Backpressure: req_ready only in IDLE; memory request held until mem_req_ready.
module dcache_assoc
    import dcache_pkg::*;
#(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned LINE_BYTES = 64,
    parameter int unsigned NUM_SETS   = 256,
    parameter int unsigned NUM_WAYS   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inv_all,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wr,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [DATA_W-1:0]       req_wdata,
    output logic                    resp_valid,
    output logic [DATA_W-1:0]       resp_rdata,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_req_wr,
    output logic [ADDR_W-1:0]       mem_req_addr,
    output logic [DATA_W-1:0]       mem_req_wdata,
    input  logic                    mem_resp_valid,
    input  logic [LINE_BYTES*8-1:0] mem_resp_data
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]             stat_hits,
    output logic [31:0]             stat_misses
`endif
);

    localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
    localparam int unsigned IDX_W  = $clog2(NUM_SETS);
    localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int unsigned LINE_W = LINE_BYTES * 8;
    localparam int unsigned WORDS  = dc_words(LINE_BYTES, DATA_W);
    localparam int unsigned WOFF_W = dc_width(WORDS);
    localparam int unsigned RR_W   = dc_width(NUM_WAYS);
    localparam int unsigned BYTE_W = $clog2(DATA_W / 8);

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    dcache_state_e                 r_state;
    req_t                          r_req;
    logic                          r_resp_valid;
    logic [DATA_W-1:0]             r_resp_rdata;
    logic                          r_mem_req_valid;
    logic                          r_mem_req_wr;
    logic [ADDR_W-1:0]             r_mem_req_addr;
    logic [DATA_W-1:0]             r_mem_req_wdata;
    logic [NUM_SETS-1:0][RR_W-1:0] r_rr;

    logic [IDX_W-1:0]    w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [WOFF_W-1:0]   w_woff;
    logic [TAG_W-1:0]    w_way_tag  [NUM_WAYS];
    logic [LINE_W-1:0]   w_way_line [NUM_WAYS];
    logic [NUM_WAYS-1:0] w_way_vld;
    logic [NUM_WAYS-1:0] w_hit_vec;
    logic [NUM_WAYS-1:0] w_hit_sel;
    logic [LINE_W-1:0]   w_hit_line;
    logic                w_hit;
    logic                w_fill_we;
    logic                w_word_we;
    logic [DATA_W-1:0]   w_hit_word;
    logic [DATA_W-1:0]   w_fill_word;

    assign w_idx  = IDX_W'(r_req.addr >> OFF_W);
    assign w_tag  = TAG_W'(r_req.addr >> (OFF_W + IDX_W));
    assign w_woff = WOFF_W'((r_req.addr >> BYTE_W) & ADDR_W'(WORDS - 1));

    assign w_fill_we = !rst && (r_state == FILL_WAIT) && mem_resp_valid;
    assign w_word_we = !rst && (r_state == LOOKUP) && r_req.wr && w_hit;

    for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
        dcache_way #(
            .NUM_SETS (NUM_SETS),
            .IDX_W    (IDX_W),
            .TAG_W    (TAG_W),
            .DATA_W   (DATA_W),
            .LINE_W   (LINE_W),
            .WOFF_W   (WOFF_W)
        ) u_way (
            .clk         (clk),
            .rst         (rst),
            .i_inv_all   (inv_all),
            .i_idx       (w_idx),
            .i_tag       (w_tag),
            .i_woff      (w_woff),
            .i_line_we   (w_fill_we && (r_rr[w_idx] == RR_W'(g))),
            .i_line_data (mem_resp_data),
            .i_word_we   (w_word_we && w_hit_sel[g]),
            .i_word_data (r_req.wdata),
            .o_tag       (w_way_tag[g]),
            .o_valid     (w_way_vld[g]),
            .o_line      (w_way_line[g])
        );
        assign w_hit_vec[g] = w_way_vld[g] && (w_way_tag[g] == w_tag);
    end

    // Descending scan so the lowest matching way is the one left selected.
    always_comb begin
        w_hit_sel  = '0;
        w_hit_line = '0;
        for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
            if (w_hit_vec[w]) begin
                w_hit_sel    = '0;
                w_hit_sel[w] = 1'b1;
                w_hit_line   = w_way_line[w];
            end
        end
        w_hit = |w_hit_vec;
    end

    assign w_hit_word  = w_hit_line[w_woff*DATA_W +: DATA_W];
    assign w_fill_word = mem_resp_data[w_woff*DATA_W +: DATA_W];

`ifdef DCACHE_STATS_EN
    logic [31:0] r_stat_hits;
    logic [31:0] r_stat_misses;
    assign stat_hits   = r_stat_hits;
    assign stat_misses = r_stat_misses;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_req           <= '0;
            r_resp_valid    <= 1'b0;
            r_resp_rdata    <= '0;
            r_mem_req_valid <= 1'b0;
            r_mem_req_wr    <= 1'b0;
            r_mem_req_addr  <= '0;
            r_mem_req_wdata <= '0;
            r_rr            <= '0;
`ifdef DCACHE_STATS_EN
            r_stat_hits     <= '0;
            r_stat_misses   <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_req   <= '{wr: req_wr, addr: req_addr, wdata: req_wdata};
                        r_state <= LOOKUP;
                    end
                end
                LOOKUP: begin
`ifdef DCACHE_STATS_EN
                    if (w_hit) begin
                        if (r_stat_hits != '1) r_stat_hits <= r_stat_hits + 32'd1;
                    end else begin
                        if (r_stat_misses != '1) r_stat_misses <= r_stat_misses + 32'd1;
                    end
`endif
                    if (r_req.wr) begin
                        r_mem_req_valid <= 1'b1;
                        r_mem_req_wr    <= 1'b1;
                        r_mem_req_addr  <= r_req.addr & ~ADDR_W'(DATA_W / 8 - 1);
                        r_mem_req_wdata <= r_req.wdata;
                        r_state         <= WRITE;
                    end else if (w_hit) begin
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_hit_word;
                        r_state      <= RESP;
                    end else begin
                        r_mem_req_valid <= 1'b1;
                        r_mem_req_wr    <= 1'b0;
                        r_mem_req_addr  <= r_req.addr & ~ADDR_W'(LINE_BYTES - 1);
                        r_state         <= FILL;
                    end
                end
                FILL: begin
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= FILL_WAIT;
                    end
                end
                FILL_WAIT: begin
                    if (mem_resp_valid) begin
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_fill_word;
                        r_rr[w_idx]  <= (r_rr[w_idx] == RR_W'(NUM_WAYS - 1)) ? '0 : r_rr[w_idx] + RR_W'(1);
                        r_state      <= RESP;
                    end
                end
                WRITE: begin
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= WRITE_WAIT;
                    end
                end
                WRITE_WAIT: begin
                    if (mem_resp_valid) begin
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= '0;
                        r_state      <= RESP;
                    end
                end
                RESP: begin
                    r_resp_valid <= 1'b0;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready     = (r_state == IDLE);
    assign resp_valid    = r_resp_valid;
    assign resp_rdata    = r_resp_rdata;
    assign mem_req_valid = r_mem_req_valid;
    assign mem_req_wr    = r_mem_req_wr;
    assign mem_req_addr  = r_mem_req_addr;
    assign mem_req_wdata = r_mem_req_wdata;

    a_single_hit: assert property (@(posedge clk) disable iff (rst)
        (r_state == LOOKUP) |-> $onehot0(w_hit_vec));

endmodule

// File: tb/tb_dcache_assoc.sv
// Directed bench for dcache_assoc at default parameters with a hand-driven memory side.
// Latency: n/a. Backpressure: memory ready is held low on demand to exercise stalls.
module tb_dcache_assoc;

    logic         clk;
    logic         rst;
    logic         inv_all;
    logic         req_valid;
    logic         req_ready;
    logic         req_wr;
    logic [63:0]  req_addr;
    logic [63:0]  req_wdata;
    logic         resp_valid;
    logic [63:0]  resp_rdata;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_wr;
    logic [63:0]  mem_req_addr;
    logic [63:0]  mem_req_wdata;
    logic         mem_resp_valid;
    logic [511:0] mem_resp_data;
`ifdef DCACHE_STATS_EN
    logic [31:0]  stat_hits;
    logic [31:0]  stat_misses;
`endif

    int checks = 0;
    int errors = 0;

    dcache_assoc dut (
        .clk            (clk),
        .rst            (rst),
        .inv_all        (inv_all),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_wr         (req_wr),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_wr     (mem_req_wr),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
`ifdef DCACHE_STATS_EN
        ,
        .stat_hits      (stat_hits),
        .stat_misses    (stat_misses)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [511:0] mk_line(input logic [63:0] base);
        logic [511:0] l;
        for (int i = 0; i < 8; i++) l[i*64 +: 64] = base + 64'(i);
        return l;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [63:0] addr, input logic [63:0] wdata, input logic inv);
        int n = 0;
        while (!req_ready && n < 50) begin tick(); n++; end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL issue_ready: req_ready=%0b required 1", req_ready);
        end
        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata; inv_all = inv;
        tick();
        req_valid = 1'b0; req_wr = 1'b0; inv_all = 1'b0;
    endtask

    task automatic wait_mem_req();
        int n = 0;
        while (!mem_req_valid && n < 50) begin tick(); n++; end
        if (!mem_req_valid) begin
            checks++; errors++;
            $display("FAIL mem_req_timeout: mem_req_valid=%0b required 1", mem_req_valid);
        end
    endtask

    // Accept the pending memory request, then return line / ack one cycle later.
    task automatic mem_handshake(input logic [511:0] line);
        mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = line; tick(); mem_resp_valid = 1'b0;
    endtask

    task automatic load(input logic [63:0] addr, input logic [511:0] line, input logic inv,
                        output logic missed, output logic [63:0] fill_addr,
                        output logic [63:0] rdata, output int lat);
        issue(1'b0, addr, 64'd0, inv);
        lat = 1;
        while (!mem_req_valid && !resp_valid && lat < 50) begin tick(); lat++; end
        missed    = mem_req_valid;
        fill_addr = mem_req_addr;
        if (missed) mem_handshake(line);
        if (!resp_valid) begin
            checks++; errors++;
            $display("FAIL load_resp_timeout: resp_valid=%0b required 1", resp_valid);
        end
        rdata = resp_rdata;
        tick();
    endtask

    task automatic store(input logic [63:0] addr, input logic [63:0] data,
                         output logic wr_seen, output logic [63:0] addr_seen,
                         output logic [63:0] data_seen, output logic [63:0] rdata);
        issue(1'b1, addr, data, 1'b0);
        wait_mem_req();
        wr_seen = mem_req_wr; addr_seen = mem_req_addr; data_seen = mem_req_wdata;
        mem_handshake('0);
        if (!resp_valid) begin
            checks++; errors++;
            $display("FAIL store_resp_timeout: resp_valid=%0b required 1", resp_valid);
        end
        rdata = resp_rdata;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 64'd0) begin
            errors++;
            $display("FAIL reset_cpu_side: ready=%0b resp_valid=%0b rdata=%h required 1/0/0", req_ready, resp_valid, resp_rdata);
        end
        checks++;
        if (mem_req_valid !== 1'b0 || mem_req_wr !== 1'b0 || mem_req_addr !== 64'd0 || mem_req_wdata !== 64'd0) begin
            errors++;
            $display("FAIL reset_mem_side: valid=%0b wr=%0b addr=%h wdata=%h required all 0", mem_req_valid, mem_req_wr, mem_req_addr, mem_req_wdata);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_cold_fill_hit();
        logic miss; logic [63:0] fa, rd; int lat;
        load(64'h1000, mk_line(64'hAA), 1'b0, miss, fa, rd, lat);
        checks++;
        if (miss !== 1'b1 || fa !== 64'h1000) begin errors++; $display("FAIL cold_fill: miss=%0b addr=%h required 1/1000", miss, fa); end
        checks++;
        if (rd !== 64'hAA) begin errors++; $display("FAIL cold_rdata: got %h required aa", rd); end
        load(64'h1000, '0, 1'b0, miss, fa, rd, lat);
        checks++;
        if (miss !== 1'b0 || rd !== 64'hAA) begin errors++; $display("FAIL reload_hit: miss=%0b rdata=%h required 0/aa", miss, rd); end
        checks++;
        if (lat != 2) begin errors++; $display("FAIL hit_latency: got %0d required 2", lat); end
        load(64'h1038, '0, 1'b0, miss, fa, rd, lat);
        checks++;
        if (miss !== 1'b0 || rd !== 64'hB1) begin errors++; $display("FAIL hit_word7: miss=%0b rdata=%h required 0/b1", miss, rd); end
    endtask

    task automatic test_eviction();
        logic miss; logic [63:0] fa, rd; int lat;
        load(64'h0000, mk_line(64'h100), 1'b0, miss, fa, rd, lat);
        load(64'h4000, mk_line(64'h200), 1'b0, miss, fa, rd, lat);
        checks++;
        if (miss !== 1'b1 || rd !== 64'h200) begin errors++; $display("FAIL evict_second_fill: miss=%0b rdata=%h required 1/200", miss, rd); end
        load(64'h8000, mk_line(64'h300), 1'b0, miss, fa, rd, lat);
        load(64'h4000, '0, 1'b0, miss, fa, rd, lat);
        checks++;
        if (miss !== 1'b0 || rd !== 64'h200) begin errors++; $display("FAIL evict_way1_kept: miss=%0b rdata=%h required 0/200", miss, rd); end
        load(64'h0000, mk_line(64'h100), 1'b0, miss, fa, rd, lat);
        checks++;
        if (miss !== 1'b1 || fa !== 64'h0000 || rd !== 64'h100) begin
            errors++; $display("FAIL evict_way0_gone: miss=%0b addr=%h rdata=%h required 1/0/100", miss, fa, rd);
        end
    endtask

    task automatic test_store_hit();
        logic wr; logic [63:0] a, d, rd, fa; logic miss; int lat;
        store(64'h1008, 64'h55, wr, a, d, rd);
        checks++;
        if (wr !== 1'b1 || a !== 64'h1008 || d !== 64'h55 || rd !== 64'd0) begin
            errors++; $display("FAIL store_hit_mem: wr=%0b addr=%h data=%h rdata=%h required 1/1008/55/0", wr, a, d, rd);
        end
        load(64'h1008, '0, 1'b0, miss, fa, rd, lat);
        checks++;
        if (miss !== 1'b0 || rd !== 64'h55) begin errors++; $display("FAIL store_hit_update: miss=%0b rdata=%h required 0/55", miss, rd); end
        load(64'h1000, '0, 1'b0, miss, fa, rd, lat);
        checks++;
        if (miss !== 1'b0 || rd !== 64'hAA) begin errors++; $display("FAIL store_hit_neighbour: miss=%0b rdata=%h required 0/aa", miss, rd); end
    endtask

    task automatic test_store_miss();
        logic wr; logic [63:0] a, d, rd, fa; logic miss; int lat;
        store(64'h2000, 64'h66, wr, a, d, rd);
        checks++;
        if (wr !== 1'b1 || a !== 64'h2000 || d !== 64'h66) begin
            errors++; $display("FAIL store_miss_mem: wr=%0b addr=%h data=%h required 1/2000/66", wr, a, d);
        end
        load(64'h2000, mk_line(64'h2000_0000), 1'b0, miss, fa, rd, lat);
        checks++;
        if (miss !== 1'b1 || fa !== 64'h2000 || rd !== 64'h2000_0000) begin
            errors++; $display("FAIL store_no_allocate: miss=%0b addr=%h rdata=%h required 1/2000/20000000", miss, fa, rd);
        end
    endtask

    task automatic test_inv_stall();
        logic miss; logic [63:0] fa, rd; int lat;
        inv_all = 1'b1; tick(); inv_all = 1'b0;
        issue(1'b0, 64'h1000, 64'd0, 1'b0);
        wait_mem_req();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (mem_req_valid !== 1'b1 || mem_req_wr !== 1'b0 || mem_req_addr !== 64'h1000) begin
                errors++; $display("FAIL stall_stable[%0d]: valid=%0b wr=%0b addr=%h required 1/0/1000", i, mem_req_valid, mem_req_wr, mem_req_addr);
            end
        end
        mem_handshake(mk_line(64'hC0));
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 64'hC0) begin
            errors++; $display("FAIL inv_refill: resp_valid=%0b rdata=%h required 1/c0", resp_valid, resp_rdata);
        end
        tick();
        load(64'h1000, mk_line(64'hD0), 1'b1, miss, fa, rd, lat);
        checks++;
        if (miss !== 1'b1 || rd !== 64'hD0) begin errors++; $display("FAIL inv_with_accept: miss=%0b rdata=%h required 1/d0", miss, rd); end
        issue(1'b0, 64'h3000, 64'd0, 1'b0);
        wait_mem_req();
        mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = mk_line(64'hE0); inv_all = 1'b1;
        tick();
        mem_resp_valid = 1'b0; inv_all = 1'b0;
        tick();
        load(64'h3000, '0, 1'b0, miss, fa, rd, lat);
        checks++;
        if (miss !== 1'b0 || rd !== 64'hE0) begin errors++; $display("FAIL inv_during_fill: miss=%0b rdata=%h required 0/e0", miss, rd); end
    endtask

    task automatic test_reset_mid_miss();
        logic miss; logic [63:0] fa, rd; int lat;
        issue(1'b0, 64'h5000, 64'd0, 1'b0);
        wait_mem_req();
        mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_req_valid !== 1'b0 || mem_req_addr !== 64'd0) begin
            errors++; $display("FAIL midmiss_reset: ready=%0b resp_valid=%0b mem_valid=%0b addr=%h required 1/0/0/0", req_ready, resp_valid, mem_req_valid, mem_req_addr);
        end
        mem_resp_valid = 1'b1; mem_resp_data = mk_line(64'h5555); tick(); mem_resp_valid = 1'b0;
        tick();
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL late_resp_ignored: resp_valid=%0b ready=%0b required 0/1", resp_valid, req_ready);
        end
        load(64'h5000, mk_line(64'h50), 1'b0, miss, fa, rd, lat);
        checks++;
        if (miss !== 1'b1 || fa !== 64'h5000 || rd !== 64'h50) begin
            errors++; $display("FAIL midmiss_reload: miss=%0b addr=%h rdata=%h required 1/5000/50", miss, fa, rd);
        end
    endtask

    initial begin
        rst = 1'b1; inv_all = 1'b0; req_valid = 1'b0; req_wr = 1'b0;
        req_addr = '0; req_wdata = '0; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_resp_data = '0;
        test_reset();
        test_cold_fill_hit();
        test_eviction();
        test_store_hit();
        test_store_miss();
        test_inv_stall();
        test_reset_mid_miss();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
